// File: rtl/missile_pool.sv
// Player-missile pool: fire-edge allocation with cooldown, per-slot upward motion,
// hit/top retirement and per-pixel sprite hit flags for the colorizer.
module missile_pool #(
  parameter  int NUM_MISSILES   = 8,
  parameter  int COORD_W        = 12,
  parameter  int STEP_CYCLES    = 250000,
  parameter  int STEP_PIX       = 2,
  parameter  int LAUNCH_ROW     = 440,
  parameter  int COL_OFS        = 15,
  parameter  int MISSILE_W      = 2,
  parameter  int MISSILE_H      = 4,
  parameter  int COOLDOWN_TICKS = 4,
  localparam int IDX_W          = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COORD_W-1:0]      pixel_row,
  input  logic [COORD_W-1:0]      pixel_column,
  input  logic [COORD_W-1:0]      player_col,
  input  logic                    fire,
  input  logic                    hit_valid,
  input  logic [IDX_W-1:0]        hit_idx,
  output logic [NUM_MISSILES-1:0] in_flight,
  output logic [NUM_MISSILES-1:0] missile_active,
  output logic [3:0]              missile_pix,
  output logic                    fire_accept,
  output logic                    fire_drop,
  output logic                    pool_full,
  output logic [15:0]             shots_fired
);

  localparam int CNT_W  = $clog2(STEP_CYCLES);
  localparam int COOL_W = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);

  localparam logic [COORD_W-1:0] LAUNCH = COORD_W'(LAUNCH_ROW);
  localparam logic [COORD_W-1:0] STEP   = COORD_W'(STEP_PIX);
  localparam logic [COOL_W-1:0]  COOL_RELOAD = COOL_W'(COOLDOWN_TICKS);

  logic                    fire_s_q, fire_q_q;
  logic [CNT_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [COOL_W-1:0]       cool_q, cool_d;
  logic [NUM_MISSILES-1:0] in_flight_q, in_flight_d;
  logic [COORD_W-1:0]      row_q [NUM_MISSILES];
  logic [COORD_W-1:0]      row_d [NUM_MISSILES];
  logic [COORD_W-1:0]      col_q [NUM_MISSILES];
  logic [COORD_W-1:0]      col_d [NUM_MISSILES];
  logic                    fire_accept_q, fire_drop_q;
  logic [15:0]             shots_q, shots_d;

  logic             fire_edge, tick, alloc, refuse, hit_ok, any_free, found;
  logic [IDX_W-1:0] alloc_idx;

  always_comb begin
    fire_edge = fire_s_q & ~fire_q_q;
    tick      = (tick_cnt_q == CNT_W'(STEP_CYCLES - 1));
    any_free  = ~(&in_flight_q);
    alloc     = fire_edge & any_free & (cool_q == '0);
    refuse    = fire_edge & ~alloc;
    hit_ok    = hit_valid && (32'(hit_idx) < NUM_MISSILES);

    // Only slots free in the registered state are candidates; lowest index wins.
    alloc_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!found && !in_flight_q[i]) begin
        alloc_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    cool_d      = cool_q;
    shots_d     = shots_q;
    in_flight_d = in_flight_q;
    row_d       = row_q;
    col_d       = col_q;

    if (alloc) begin
      cool_d  = COOL_RELOAD;
      shots_d = shots_q + 16'd1;
    end else if (tick && cool_q != '0) begin
      cool_d = cool_q - 1'b1;
    end

    // Per slot: launch beats hit beats motion; a freshly launched slot never moves.
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (alloc && alloc_idx == IDX_W'(i)) begin
        row_d[i]       = LAUNCH;
        col_d[i]       = player_col;
        in_flight_d[i] = 1'b1;
      end else if (hit_ok && 32'(hit_idx) == i) begin
        in_flight_d[i] = 1'b0;
      end else if (tick && in_flight_q[i]) begin
        if (row_q[i] < STEP) begin
          in_flight_d[i] = 1'b0;
          row_d[i]       = LAUNCH;
        end else begin
          row_d[i] = row_q[i] - STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_s_q      <= 1'b0;
      fire_q_q      <= 1'b0;
      tick_cnt_q    <= '0;
      cool_q        <= '0;
      in_flight_q   <= '0;
      fire_accept_q <= 1'b0;
      fire_drop_q   <= 1'b0;
      shots_q       <= '0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        row_q[i] <= LAUNCH;
        col_q[i] <= '0;
      end
    end else begin
      fire_s_q      <= fire;
      fire_q_q      <= fire_s_q;
      tick_cnt_q    <= tick_cnt_d;
      cool_q        <= cool_d;
      in_flight_q   <= in_flight_d;
      fire_accept_q <= alloc;
      fire_drop_q   <= refuse;
      shots_q       <= shots_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  // Sprite window compared one bit wider so row+H and col+OFS+W never wrap.
  logic [COORD_W:0] pr_x, pc_x, r_x, c_x;

  always_comb begin
    pr_x = {1'b0, pixel_row};
    pc_x = {1'b0, pixel_column};
    r_x  = '0;
    c_x  = '0;
    missile_active = '0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      r_x = {1'b0, row_q[i]};
      c_x = {1'b0, col_q[i]} + (COORD_W+1)'(COL_OFS);
      missile_active[i] = in_flight_q[i]
                        && (pr_x >= r_x + (COORD_W+1)'(1))
                        && (pr_x <= r_x + (COORD_W+1)'(MISSILE_H))
                        && (pc_x >= c_x)
                        && (pc_x <= c_x + (COORD_W+1)'(MISSILE_W - 1));
    end
  end

  assign in_flight   = in_flight_q;
  assign pool_full   = &in_flight_q;
  assign missile_pix = (|missile_active) ? 4'hF : 4'h0;
  assign fire_accept = fire_accept_q;
  assign fire_drop   = fire_drop_q;
  assign shots_fired = shots_q;

endmodule

// File: tb/tb_missile_pool.sv
// Bench for missile_pool: fire responses go through an expectation queue checked by a
// monitor; slot geometry and flags are checked directly with hand-computed rows.
`timescale 1ns/1ps
module tb_missile_pool;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pixel_row = '0, pixel_column = '0, player_col = 12'd100;
  logic        fire = 1'b0, hit_valid = 1'b0;
  logic [1:0]  hit_idx = '0;
  logic [N-1:0] in_flight, missile_active;
  logic [3:0]  missile_pix;
  logic        fire_accept, fire_drop, pool_full;
  logic [15:0] shots_fired;

  missile_pool #(
    .NUM_MISSILES(N), .COORD_W(12), .STEP_CYCLES(4), .STEP_PIX(2), .LAUNCH_ROW(440),
    .COL_OFS(15), .MISSILE_W(2), .MISSILE_H(4), .COOLDOWN_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .player_col(player_col), .fire(fire), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .in_flight(in_flight), .missile_active(missile_active), .missile_pix(missile_pix),
    .fire_accept(fire_accept), .fire_drop(fire_drop), .pool_full(pool_full),
    .shots_fired(shots_fired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int launch_cyc [N];
  int shots_exp = 0;

  typedef struct {
    bit          acc;
    logic [15:0] shots;
    logic [N-1:0] inf;
  } exp_t;
  exp_t exp_q[$];

  // posedges since reset release; ticks land on posedges where cyc % 4 == 0
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && (fire_accept || fire_drop)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: accept=%0b drop=%0b with empty queue", fire_accept, fire_drop);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_accept", {31'd0, fire_accept}, {31'd0, e.acc});
        chk("sb_drop",   {31'd0, fire_drop},   {31'd0, !e.acc});
        chk("sb_shots",  {16'd0, shots_fired}, {16'd0, e.shots});
        chk("sb_inflight", {28'd0, in_flight}, {28'd0, e.inf});
      end
    end
  end

  // fire high at this negedge; launch/refusal happens on the 2nd posedge after
  task automatic do_fire(input bit acc, input logic [N-1:0] exp_if, input int slot);
    exp_t e;
    if (acc) shots_exp++;
    e.acc = acc; e.shots = 16'(shots_exp); e.inf = exp_if;
    exp_q.push_back(e);
    fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fire = 1'b0;
    if (acc) launch_cyc[slot] = cyc;
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      while (cyc % 4 != 0) @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int exp_row(input int slot);
    return 440 - 2 * (cyc / 4 - launch_cyc[slot] / 4);
  endfunction

  // sweep the sprite edges of one slot within half a clock period
  task automatic probe(input int slot, input int row, input int col);
    pixel_column = 12'(col + 15);
    pixel_row = 12'(row);     #0.5 chk($sformatf("act%0d_row_above", slot), 32'(missile_active[slot]), 0);
    pixel_row = 12'(row + 1); #0.5 chk($sformatf("act%0d_row_first", slot), 32'(missile_active[slot]), 1);
    chk("pix_on", 32'(missile_pix), 32'hF);
    pixel_row = 12'(row + 4); #0.5 chk($sformatf("act%0d_row_last", slot),  32'(missile_active[slot]), 1);
    pixel_row = 12'(row + 5); #0.5 chk($sformatf("act%0d_row_below", slot), 32'(missile_active[slot]), 0);
    pixel_row = 12'(row + 2);
    pixel_column = 12'(col + 14); #0.5 chk($sformatf("act%0d_col_left", slot),  32'(missile_active[slot]), 0);
    pixel_column = 12'(col + 16); #0.5 chk($sformatf("act%0d_col_last", slot),  32'(missile_active[slot]), 1);
    pixel_column = 12'(col + 17); #0.5 chk($sformatf("act%0d_col_right", slot), 32'(missile_active[slot]), 0);
    pixel_row = '0; pixel_column = '0;
  endtask

  initial begin
    #2;
    chk("rst_inflight", 32'(in_flight), 0);
    chk("rst_pix", 32'(missile_pix), 0);
    chk("rst_shots", 32'(shots_fired), 0);
    chk("rst_full", 32'(pool_full), 0);
    @(negedge clk) rst = 1'b1;

    // single launch, then one step, then cooldown refusal and acceptance
    wait_cyc(3);
    do_fire(1, 4'b0001, 0);                   // launch @5
    probe(0, 440, 100);
    wait_ticks(1);                            // cyc 8
    probe(0, 438, 100);
    do_fire(0, 4'b0001, 0);                   // @10, cooldown 2 -> drop
    wait_ticks(2);                            // cyc 16
    do_fire(1, 4'b0011, 1);                   // @18, three ticks after launch
    wait_ticks(3);
    do_fire(1, 4'b0111, 2);                   // @30
    wait_ticks(3);
    do_fire(1, 4'b1111, 3);                   // @42
    chk("pool_full_set", 32'(pool_full), 1);
    wait_ticks(3);
    do_fire(0, 4'b1111, 0);                   // @54, pool full
    hit_valid = 1'b1; hit_idx = 2'd2;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hit2_inflight", 32'(in_flight), 32'h0B);
    chk("hit2_full", 32'(pool_full), 0);
    do_fire(1, 4'b1111, 2);                   // @57 refills slot 2
    hit_valid = 1'b1; hit_idx = 2'd1;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hit1_inflight", 32'(in_flight), 32'h0D);

    // fire edge, tick and hit on slot 0 on the same posedge (72)
    wait_ticks(3);
    @(negedge clk); @(negedge clk);           // cyc 70
    shots_exp++;
    exp_q.push_back('{acc: 1'b1, shots: 16'(shots_exp), inf: 4'b1110});
    fire = 1'b1;
    @(negedge clk);
    hit_valid = 1'b1; hit_idx = 2'd0;
    @(negedge clk);
    hit_valid = 1'b0; fire = 1'b0;
    launch_cyc[1] = cyc;
    chk("simul_cyc", 32'(cyc % 4), 0);
    probe(1, 440, 100);
    hit_valid = 1'b1; hit_idx = 2'd0;         // slot 0 now free: ignored
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hit_free_ignored", 32'(in_flight), 32'h0E);
    chk("row2_expected", 32'(exp_row(2)), 432);
    probe(2, exp_row(2), 100);
    @(negedge clk);
    chk("row3_expected", 32'(exp_row(3)), 424);
    probe(3, exp_row(3), 100);

    // top retirement
    wait_cyc(920);
    chk("ret_920", 32'(in_flight), 32'h0E);
    probe(3, 0, 100);
    wait_cyc(924);
    chk("ret_924", 32'(in_flight), 32'h06);
    wait_cyc(940);
    chk("ret_940", 32'(in_flight), 32'h02);
    wait_cyc(952);
    chk("ret_952", 32'(in_flight), 32'h02);
    probe(1, 0, 100);
    wait_cyc(956);
    chk("ret_956", 32'(in_flight), 32'h00);
    pixel_row = 12'd1; pixel_column = 12'd115;
    #1 chk("pix_off", 32'(missile_pix), 0);

    // reset in flight
    @(negedge clk);
    do_fire(1, 4'b0001, 0);
    wait_ticks(3);
    do_fire(1, 4'b0011, 1);
    wait_ticks(3);
    do_fire(1, 4'b0111, 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_inflight", 32'(in_flight), 0);
    chk("mid_rst_active", 32'(missile_active), 0);
    chk("mid_rst_pix", 32'(missile_pix), 0);
    chk("mid_rst_shots", 32'(shots_fired), 0);
    chk("mid_rst_accept", 32'(fire_accept), 0);
    shots_exp = 0;
    @(negedge clk) rst = 1'b1;
    player_col = 12'd300;
    do_fire(1, 4'b0001, 0);
    probe(0, 440, 300);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
